// File: rtl/charge_stat_encoder.sv
`default_nettype none
// ============================================================================
// Module   : charge_stat_encoder
// Brief    : Drives the open-drain STAT line from charger condition:
//            pulled down while charging, released when off/done, blinking on fault.
// Revision : 1.0
// ============================================================================
module charge_stat_encoder #(
    parameter int BLINK_HALF = 16384,
    parameter int HOLD       = 328
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       charging,
    input  logic       done,
    input  logic       fault,
    input  logic       fault_clr,
    output logic       stat_pd,
    output logic [1:0] state,
    output logic [7:0] fault_events
);

    localparam int c_HOLD_W  = $clog2(HOLD + 1);
    localparam int c_BLINK_W = $clog2(BLINK_HALF);

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_CHARGE = 2'b01,
        ST_DONE   = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    logic                 r_s_en_q,   w_s_en_d;
    logic                 r_s_chg_q,  w_s_chg_d;
    logic                 r_s_done_q, w_s_done_d;
    logic                 r_s_flt_q,  w_s_flt_d;
    logic                 r_s_clr_q,  w_s_clr_d;
    logic                 r_flt_lat_q, w_flt_lat_d;
    state_t               r_cand_q,   w_cand_d;
    state_t               r_state_q,  w_state_d;
    logic [c_HOLD_W-1:0]  r_hold_cnt_q, w_hold_cnt_d;
    logic [c_BLINK_W-1:0] r_blink_cnt_q, w_blink_cnt_d;
    logic                 r_phase_q,  w_phase_d;
    logic                 r_stat_pd_q, w_stat_pd_d;
    logic [7:0]           r_fault_events_q, w_fault_events_d;
    logic [c_HOLD_W-1:0]  w_cnt_inc;

    always_comb begin
        w_s_en_d         = en;
        w_s_chg_d        = charging;
        w_s_done_d       = done;
        w_s_flt_d        = fault;
        w_s_clr_d        = fault_clr;
        w_flt_lat_d      = r_flt_lat_q;
        w_cand_d         = ST_OFF;
        w_state_d        = r_state_q;
        w_hold_cnt_d     = r_hold_cnt_q;
        w_blink_cnt_d    = '0;
        w_phase_d        = 1'b0;
        w_stat_pd_d      = 1'b0;
        w_fault_events_d = r_fault_events_q;
        w_cnt_inc        = '0;

        if (r_s_flt_q) begin
            w_flt_lat_d = 1'b1;
        end else if (r_s_clr_q) begin
            w_flt_lat_d = 1'b0;
        end

        // A fault seen this cycle counts immediately so FAULT is one edge behind sync.
        if (!r_s_en_q) begin
            w_cand_d = ST_OFF;
        end else if (r_flt_lat_q || r_s_flt_q) begin
            w_cand_d = ST_FAULT;
        end else if (r_s_chg_q) begin
            w_cand_d = ST_CHARGE;
        end else if (r_s_done_q) begin
            w_cand_d = ST_DONE;
        end

        if (w_cand_d != r_cand_q || r_hold_cnt_q == '0) begin
            w_cnt_inc = c_HOLD_W'(1);
        end else begin
            w_cnt_inc = r_hold_cnt_q + c_HOLD_W'(1);
        end

        if (!r_s_en_q || w_cand_d == ST_FAULT) begin
            w_state_d    = w_cand_d;
            w_hold_cnt_d = '0;
        end else if (w_cand_d == r_state_q) begin
            w_hold_cnt_d = '0;
        end else if (w_cnt_inc == c_HOLD_W'(HOLD)) begin
            w_state_d    = w_cand_d;
            w_hold_cnt_d = '0;
        end else begin
            w_hold_cnt_d = w_cnt_inc;
        end

        if (w_state_d == ST_FAULT) begin
            if (r_state_q != ST_FAULT) begin
                w_blink_cnt_d = '0;
                w_phase_d     = 1'b1;
                if (r_fault_events_q != 8'hFF) begin
                    w_fault_events_d = r_fault_events_q + 8'd1;
                end
            end else if (r_blink_cnt_q == c_BLINK_W'(BLINK_HALF - 1)) begin
                w_blink_cnt_d = '0;
                w_phase_d     = ~r_phase_q;
            end else begin
                w_blink_cnt_d = r_blink_cnt_q + c_BLINK_W'(1);
                w_phase_d     = r_phase_q;
            end
        end

        case (w_state_d)
            ST_CHARGE: w_stat_pd_d = 1'b1;
            ST_FAULT:  w_stat_pd_d = w_phase_d;
            default:   w_stat_pd_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_en_q         <= 1'b0;
            r_s_chg_q        <= 1'b0;
            r_s_done_q       <= 1'b0;
            r_s_flt_q        <= 1'b0;
            r_s_clr_q        <= 1'b0;
            r_flt_lat_q      <= 1'b0;
            r_cand_q         <= ST_OFF;
            r_state_q        <= ST_OFF;
            r_hold_cnt_q     <= '0;
            r_blink_cnt_q    <= '0;
            r_phase_q        <= 1'b0;
            r_stat_pd_q      <= 1'b0;
            r_fault_events_q <= 8'd0;
        end else begin
            r_s_en_q         <= w_s_en_d;
            r_s_chg_q        <= w_s_chg_d;
            r_s_done_q       <= w_s_done_d;
            r_s_flt_q        <= w_s_flt_d;
            r_s_clr_q        <= w_s_clr_d;
            r_flt_lat_q      <= w_flt_lat_d;
            r_cand_q         <= w_cand_d;
            r_state_q        <= w_state_d;
            r_hold_cnt_q     <= w_hold_cnt_d;
            r_blink_cnt_q    <= w_blink_cnt_d;
            r_phase_q        <= w_phase_d;
            r_stat_pd_q      <= w_stat_pd_d;
            r_fault_events_q <= w_fault_events_d;
        end
    end

    assign stat_pd      = r_stat_pd_q;
    assign state        = r_state_q;
    assign fault_events = r_fault_events_q;

endmodule
`default_nettype wire

// File: doc/charge_stat_encoder.md
# charge_stat_encoder

Charger-side driver for the STAT status line that the indicator block decodes. It encodes charger condition onto one open-drain pin: pulled down while charging, released (pulled high) when not charging or done, and toggled at a fixed rate on fault. It sits in the charger-emulation/power-path logic of PowerGear and closes the loop with the indicator's window-comparator decode (neg/pos/blink).

## Interface
- BLINK_HALF, 16384: clocks per blink half-period (0.5 s at 32.768 kHz); ≥2
- HOLD, 328: consecutive sampled cycles a non-fault request must persist before STAT changes; ≥1
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  encoder enable; 0 forces OFF
- charging  in  1  charger reports active charge
- done  in  1  charger reports charge complete
- fault  in  1  charger fault condition (level)
- fault_clr  in  1  single-cycle request to clear the latched fault
- stat_pd  out  1  1 = assert open-drain pull-down on STAT, 0 = release
- state  out  2  00 OFF, 01 CHARGE, 10 DONE, 11 FAULT
- fault_events  out  8  saturating count of FAULT entries

## Operation
- All five inputs pass through one sync flop (s_en, s_chg, s_done, s_flt); all logic uses the synced copies.
- Fault latch flt_lat: set on any cycle s_flt=1. Cleared only on a cycle with fault_clr=1 and s_flt=0. fault_clr while s_flt=1 is ignored.
- Candidate (priority order): s_en=0 → OFF; flt_lat=1 → FAULT; s_chg → CHARGE; s_done → DONE; else OFF. charging and done both high → CHARGE.
- FSM states OFF, CHARGE, DONE, FAULT.
  - Candidate FAULT: state ← FAULT on the next edge, with no hold.
  - s_en=0: state ← OFF on the next edge, with no hold. flt_lat is kept, so FAULT resumes once en returns.
  - Other candidates ≠ state pass through the hold filter. hold_cnt restarts at 1 whenever the candidate differs from the previous cycle's candidate. state ← candidate on the edge where the same candidate has been present for HOLD consecutive cycles.
  - Candidate = state: hold_cnt ← 0.
- stat_pd by state:
  - CHARGE: 1.
  - OFF and DONE: 0.
  - FAULT: blink phase.
- Blink:
  - On entry to FAULT, phase ← 1 and blink_cnt ← 0.
  - blink_cnt counts 0..BLINK_HALF-1. At the wrap, phase toggles.
  - Result: 50% duty square wave with period 2·BLINK_HALF, starting pulled down.
  - Leaving FAULT clears blink_cnt and phase.
- fault_events increments by 1 on each transition into FAULT and saturates at 255. Only rst clears it.

## Timing
- Reset values:
  - stat_pd=0, state=00 (OFF), fault_events=0.
  - flt_lat=0, hold_cnt=0, blink_cnt=0, phase=0.
  - All sync flops cleared.
- Latency from an input change applied before edge n:
  - fault: state=FAULT and stat_pd=1 after edge n+1.
  - Non-fault requests: new state after edge n+HOLD.
  - en falling: OFF after edge n+1.
- stat_pd is registered and changes on the same edge as state.
- Request glitch shorter than HOLD cycles: no change on stat_pd or state.
- fault_clr accepted at edge n: flt_lat clears at n+1. The new candidate then goes through the full HOLD filter, so state leaves FAULT at n+HOLD+1 at the earliest.
- fault pulse of one cycle still latches, so FAULT persists until fault_clr.
- rst mid-FAULT: everything returns to reset values, including flt_lat. If fault is still high, FAULT is re-entered 2 edges after rst is released, and fault_events counts it again.
- FAULT→FAULT (new fault while latched): no re-entry, no count, and blink continues without phase reset.

## Test plan
All scenarios use BLINK_HALF=4 and HOLD=3.
- Reset: hold rst=1 for 3 cycles with all inputs 1, then sample → stat_pd=0, state=00, fault_events=0. After release, expect FAULT 2 edges later and fault_events=1.
- Charge/done: en=1, charging=1 → state=01 and stat_pd=1 exactly 3 edges after sync. Then charging=0, done=1 → state=10 and stat_pd=0 3 edges later.
- Glitch reject: from DONE, pulse charging=1 for 2 cycles → state stays 10 and stat_pd stays 0 throughout.
- Fault blink: fault=1 for 1 cycle from CHARGE → state=11 two edges later. stat_pd then reads 1,1,1,1,0,0,0,0,1… and fault_events=1.
- Clear: fault_clr while fault=1 → stays FAULT. fault_clr with fault=0 and done=1 → state=10 four edges after the fault_clr edge (latch clears, then 3-cycle hold).
- Enable/saturation: en=0 in FAULT → OFF next edge, stat_pd=0. en=1 → FAULT again and count increments. Repeat 300 fault entries → fault_events=255.
